// File: rtl/keypad_entry_ctrl_if.sv
// ---------------------------------------------------------------------------
// keypad_entry_ctrl_if
//   Groups the scanner-side key inputs and the display/result outputs of the
//   keypad entry controller into one bundle.
//
//   Signals:
//     key_pressed  scanner sees a key down this cycle (level)
//     key_code     scanner key code, valid while key_pressed=1
//     entry_value  committed BCD value, digit3 in [15:12]
//     entry_valid  one-cycle pulse when entry_value updates
//     entry_err    one-cycle pulse on a rejected key
//     digit_count  digits currently held in the entry buffer (0..4)
//     disp_digit   BCD nibble for the currently lit digit
//     an           anodes, active-low one-hot
//
//   Modports:
//     master  key source / display consumer (scanner + segment driver side)
//     slave   the controller itself
// ---------------------------------------------------------------------------
interface keypad_entry_ctrl_if;
  logic        key_pressed;
  logic [3:0]  key_code;
  logic [15:0] entry_value;
  logic        entry_valid;
  logic        entry_err;
  logic [2:0]  digit_count;
  logic [3:0]  disp_digit;
  logic [3:0]  an;

  modport master (
    output key_pressed, key_code,
    input  entry_value, entry_valid, entry_err, digit_count, disp_digit, an
  );

  modport slave (
    input  key_pressed, key_code,
    output entry_value, entry_valid, entry_err, digit_count, disp_digit, an
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_entry_ctrl
//   Sits between a 4x4 keypad scanner and a 4-digit seven-segment driver.
//   Debounces key presses and releases, interprets keys 0-9 as digit entry and
//   A/B/C as Enter/Backspace/Clear, keeps a 4-digit BCD entry buffer, publishes
//   the buffer on Enter, and time-multiplexes the live buffer onto the anodes.
//
//   Parameters:
//     DEBOUNCE_CYCLES  stable cycles required for press and for release (>=2)
//     REFRESH_CYCLES   clk cycles each digit stays lit (>=2)
//
//   Ports:
//     clk  system clock
//     rst  synchronous reset, active-low
//     kp   keypad_entry_ctrl_if.slave (key inputs, result and display outputs)
//
//   Build option:
//     KEYPAD_LEADING_BLANK_EN  when defined, digit positions at or above
//                              digit_count are blanked (an=1111, nibble 0);
//                              position 0 stays lit showing 0 on an empty
//                              buffer. Undefined: all four digits always lit.
// ---------------------------------------------------------------------------
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REFRESH_CYCLES  = 100000
) (
  input  logic               clk,
  input  logic               rst,
  keypad_entry_ctrl_if.slave kp
);

  localparam int NUM_DIGITS = 4;
  localparam int DB_W       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int REF_W      = (REFRESH_CYCLES  > 2) ? $clog2(REFRESH_CYCLES)  : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    ACCEPT,
    HOLD,
    RELEASE_DB
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [DB_W-1:0]  cnt_q,   cnt_d;
  logic [3:0]       key_q,   key_d;

  logic [15:0]      buf_q,   buf_d;
  logic [2:0]       dcnt_q,  dcnt_d;
  logic [15:0]      val_q,   val_d;
  logic             valid_q, valid_d;
  logic             err_q,   err_d;

  logic [REF_W-1:0] ref_q,   ref_d;
  logic [1:0]       idx_q,   idx_d;
  logic [3:0]       an_q,    an_d;
  logic [3:0]       dig_q,   dig_d;

  // ---------------------------------------------------------------------------
  // Debounce / key FSM
  //   The IDLE->PRESS_DB cycle counts as the first high sample, so an accepted
  //   press needs DEBOUNCE_CYCLES+1 consecutive high samples and the action is
  //   registered DEBOUNCE_CYCLES+1 edges after the first one.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    unique case (state_q)
      IDLE: begin
        if (kp.key_pressed) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!kp.key_pressed) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          key_d   = kp.key_code;
          state_d = ACCEPT;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      ACCEPT: begin
        state_d = HOLD;
      end
      HOLD: begin
        // No auto-repeat: only a debounced release re-arms IDLE.
        if (!kp.key_pressed) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (kp.key_pressed) begin
          state_d = HOLD;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Key actions, executed only during the single ACCEPT cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    buf_d   = buf_q;
    dcnt_d  = dcnt_q;
    val_d   = val_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (state_q == ACCEPT) begin
      if (key_q <= 4'h9) begin
        if (dcnt_q < 3'd4) begin
          buf_d  = {buf_q[11:0], key_q};
          dcnt_d = dcnt_q + 3'd1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        unique case (key_q)
          4'hA: begin
            if (dcnt_q != 3'd0) begin
              val_d   = buf_q;
              valid_d = 1'b1;
              buf_d   = '0;
              dcnt_d  = '0;
            end else begin
              err_d = 1'b1;
            end
          end
          4'hB: begin
            // Backspace on an empty buffer is a silent no-op.
            buf_d = {4'h0, buf_q[15:4]};
            if (dcnt_q != 3'd0) dcnt_d = dcnt_q - 3'd1;
          end
          4'hC: begin
            buf_d  = '0;
            dcnt_d = '0;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display multiplexing
  //   idx/an/disp advance together on the refresh wrap, so the display samples
  //   the buffer as it stands at that edge; a buffer change lands on the next
  //   wrap, never mid-digit.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][3:0] nib_w;
  logic                       wrap_w;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign nib_w[g] = buf_q[g*4 +: 4];
  end

  assign wrap_w = (ref_q == REF_LAST);

  always_comb begin
    ref_d = wrap_w ? '0 : ref_q + REF_W'(1);
    idx_d = idx_q;
    an_d  = an_q;
    dig_d = dig_q;
    if (wrap_w) begin
      idx_d = idx_q + 2'd1;
      an_d  = ~(4'b0001 << idx_d);
      dig_d = nib_w[idx_d];
`ifdef KEYPAD_LEADING_BLANK_EN
      // Blank positions with no entered digit; an empty buffer keeps a lone 0.
      if (({1'b0, idx_d} >= dcnt_q) && !((dcnt_q == 3'd0) && (idx_d == 2'd0))) begin
        an_d  = 4'b1111;
        dig_d = 4'h0;
      end
`else
      // All four positions always lit, leading zeros shown.
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      buf_q   <= '0;
      dcnt_q  <= '0;
      val_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1111;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      buf_q   <= buf_d;
      dcnt_q  <= dcnt_d;
      val_q   <= val_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      dig_q   <= dig_d;
    end
  end

  assign kp.entry_value = val_q;
  assign kp.entry_valid = valid_q;
  assign kp.entry_err   = err_q;
  assign kp.digit_count = dcnt_q;
  assign kp.disp_digit  = dig_q;
  assign kp.an          = an_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_entry_ctrl
//   Self-checking bench for keypad_entry_ctrl with DEBOUNCE_CYCLES=4,
//   REFRESH_CYCLES=2. Every press goes through a behavioural key model that
//   pushes the expected entry_valid / entry_err pulse (value and cycle) into a
//   scoreboard; a negedge monitor pops and compares each pulse the DUT emits.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_keypad_entry_ctrl;

  localparam int DB  = 4;
  localparam int REF = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_entry_ctrl_if bus();

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REFRESH_CYCLES (REF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (bus)
  );

  typedef struct {
    logic        err;
    logic [15:0] val;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_buf = '0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected effect of one accepted key; pulse due DB+2 cycle counts after
  // the negedge on which the press is first driven.
  task automatic model_key(input logic [3:0] k, input int cs);
    exp_t e;
    e.cyc = cs + DB + 2;
    e.val = '0;
    e.err = 1'b0;
    if (k <= 4'h9) begin
      if (m_cnt < 4) begin
        m_buf = {m_buf[11:0], k};
        m_cnt++;
      end else begin
        e.err = 1'b1;
        sb_q.push_back(e);
      end
    end else if (k == 4'hA) begin
      if (m_cnt > 0) begin
        e.val = m_buf;
        sb_q.push_back(e);
        m_buf = '0;
        m_cnt = 0;
      end else begin
        e.err = 1'b1;
        sb_q.push_back(e);
      end
    end else if (k == 4'hB) begin
      m_buf = m_buf >> 4;
      if (m_cnt > 0) m_cnt--;
    end else if (k == 4'hC) begin
      m_buf = '0;
      m_cnt = 0;
    end
  endtask

  task automatic press(input logic [3:0] code);
    int cs;
    @(negedge clk);
    cs = cyc;
    model_key(code, cs);
    bus.key_pressed = 1'b1;
    bus.key_code    = code;
    repeat (10) @(negedge clk);
    bus.key_pressed = 1'b0;
    repeat (8) @(negedge clk);
    chk("digit_count", 32'(bus.digit_count), 32'(m_cnt));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_value"}, 32'(bus.entry_value), 32'h0);
    chk({tag, "_count"}, 32'(bus.digit_count), 32'h0);
    chk({tag, "_an"},    32'(bus.an),          32'hF);
    chk({tag, "_disp"},  32'(bus.disp_digit),  32'h0);
    chk({tag, "_pulse"}, 32'({bus.entry_valid, bus.entry_err}), 32'h0);
  endtask

  // Scoreboard monitor: every pulse must match the queue head; an expected
  // pulse whose cycle has passed is reported missing.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.entry_valid || bus.entry_err) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", 32'({bus.entry_valid, bus.entry_err}), 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("pulse_kind", 32'({bus.entry_valid, bus.entry_err}), e.err ? 32'h1 : 32'h2);
          if (!e.err) chk("entry_value", 32'(bus.entry_value), 32'(e.val));
          chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
        chk("pulse_missing", 32'(cyc), 32'(sb_q[0].cyc));
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] bounce;
    int         cs;
    bus.key_pressed = 1'b0;
    bus.key_code    = 4'h0;

    // Reset state and first anode timing
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst0");
    rst = 1'b1;
    @(negedge clk);
    chk("an_first_wait", 32'(bus.an), 32'hF);
    @(negedge clk);
    chk("an_first_lit", 32'(bus.an), 32'hD);

    // Key 7: result appears exactly DB+1 edges after the first high sample
    @(negedge clk);
    cs = cyc;
    model_key(4'h7, cs);
    bus.key_pressed = 1'b1;
    bus.key_code    = 4'h7;
    repeat (5) @(negedge clk);
    chk("latency_before", 32'(bus.digit_count), 32'h0);
    @(negedge clk);
    chk("latency_at", 32'(bus.digit_count), 32'h1);
    repeat (4) @(negedge clk);
    bus.key_pressed = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_no_repeat", 32'(bus.digit_count), 32'(m_cnt));

    // Bounce: 1,1,0,1,1,1,1 then steady; only one accept, after the last run
    press(4'hC);
    bounce = 7'b1111011;
    bus.key_code = 4'h3;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.key_pressed = bounce[i];
    end
    @(negedge clk);
    chk("bounce_early", 32'(bus.digit_count), 32'h0);
    model_key(4'h3, cyc);
    repeat (8) @(negedge clk);
    bus.key_pressed = 1'b0;
    repeat (8) @(negedge clk);
    chk("bounce_count", 32'(bus.digit_count), 32'h1);

    // Full buffer, overflow error, Enter commits 0x1234
    press(4'hC);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    press(4'h5);
    press(4'hA);
    chk("commit_value", 32'(bus.entry_value), 32'h1234);

    // Backspace, ignored key, Enter, Enter on empty
    press(4'h9);
    press(4'h8);
    press(4'hE);
    press(4'hB);
    press(4'hA);
    press(4'hA);
    press(4'hB);
    chk("value_kept", 32'(bus.entry_value), 32'h0009);

    // Display of 0x0042
    press(4'h4);
    press(4'h2);
    for (int i = 0; i < 16 && bus.an !== 4'b1101; i++) @(negedge clk);
    chk("an_sync", 32'(bus.an), 32'hD);
    for (int k = 0; k < 4; k++) begin
      int         idx;
      logic [3:0] e_an;
      logic [3:0] e_dig;
      idx   = (k + 1) % 4;
      e_an  = ~(4'b0001 << idx);
      e_dig = m_buf[idx*4 +: 4];
`ifdef KEYPAD_LEADING_BLANK_EN
      if (idx >= m_cnt && !(m_cnt == 0 && idx == 0)) begin
        e_an  = 4'b1111;
        e_dig = 4'h0;
      end
`endif
      chk("disp_an",    32'(bus.an),         32'(e_an));
      chk("disp_digit", 32'(bus.disp_digit), 32'(e_dig));
      repeat (REF) @(negedge clk);
    end

    // Reset during PRESS_DB
    bus.key_code    = 4'h5;
    bus.key_pressed = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.key_pressed = 1'b0;
    m_buf = '0;
    m_cnt = 0;
    @(negedge clk);
    chk_reset_outputs("rst_pdb");
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_pdb_after", 32'(bus.digit_count), 32'h0);

    // Reset during HOLD (key accepted, still held)
    bus.key_code    = 4'h6;
    bus.key_pressed = 1'b1;
    repeat (8) @(negedge clk);
    chk("hold_accepted", 32'(bus.digit_count), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_hold");
    bus.key_pressed = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_hold_after", 32'(bus.digit_count), 32'h0);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
